adder_result_fifo: RTL and testbench



---
 rtl/adder_pipe_pkg.sv | 24 ++
 rtl/adder_result_fifo_sync_fifo.sv | 70 +++++++
 rtl/adder_result_fifo.sv | 117 +++++++++++
 tb/tb_adder_result_fifo.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pipe_pkg.sv
// Shared definitions for the 8-bit two-stage pipelined adder and its result buffering.
//   ADDER_W       : adder sum width
//   ADDER_LATENCY : cycles from operands applied until {C_out, Sum} is stable
//   RES_W         : width of one captured result, {cout, sum}
//   result_t      : packed result record, cout in the MSB
package adder_pipe_pkg;

  localparam int unsigned ADDER_W       = 8;
  localparam int unsigned ADDER_LATENCY = 1;
  localparam int unsigned RES_W         = ADDER_W + 1;

  typedef struct packed {
    logic               cout;
    logic [ADDER_W-1:0] sum;
  } result_t;

  function automatic result_t pack_result(input logic cout, input logic [ADDER_W-1:0] sum);
    result_t r;
    r.cout = cout;
    r.sum  = sum;
    return r;
  endfunction

endpackage

// File: rtl/adder_result_fifo_sync_fifo.sv
// Generic synchronous FIFO: DEPTH x WIDTH storage, wrapping pointers, occupancy count.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   wr_en, wr_data    : push request; ignored when full unless a pop happens the same cycle
//   rd_en             : pop request; ignored when empty
//   rd_data           : head entry, forced to 0 while empty
//   full, empty       : derived from the registered count
//   count             : occupied entries, 0..DEPTH
module sync_fifo
  import adder_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = RES_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_wr;
  logic             do_rd;

  always_comb begin
    full  = (count_q == CNT_W'(DEPTH));
    empty = (count_q == '0);
    do_rd = rd_en & ~empty;
    // A full FIFO can still take a write when the head leaves in the same cycle.
    do_wr = wr_en & (~full | do_rd);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: rd_data is masked while empty.
  always_ff @(posedge clk) begin
    if (do_wr && !rst) mem_q[wr_ptr_q] <= wr_data;
  end

  always_comb begin
    rd_data = empty ? '0 : mem_q[rd_ptr_q];
    count   = count_q;
  end

endmodule

// File: rtl/adder_result_fifo.sv
// Result capture and buffering downstream of the pipelined adder.
// Each op_valid is tagged and delayed LATENCY cycles; when the tag emerges (cap) the adder's
// {cout_in, sum_in} is pushed into a DEPTH-entry FIFO, or dropped and counted when no room.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   op_valid             : operands presented to the adder this cycle
//   sum_in, cout_in      : adder outputs, sampled on the cap cycle
//   res_valid/res_ready  : output handshake, res_data = {cout, sum} at the FIFO head
//   full, empty, count   : FIFO occupancy (full/empty usable as upstream throttle)
//   drop_cnt             : saturating count of results lost to overflow
// Optional (macro RESULT_STATS_EN):
//   carry_cnt            : saturating count of accepted results with cout=1
//   max_sum              : largest accepted sum since reset
module adder_result_fifo
  import adder_pipe_pkg::*;
#(
  parameter int unsigned DATA_W  = ADDER_W,
  parameter int unsigned LATENCY = ADDER_LATENCY,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned DROP_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   op_valid,
  input  logic [DATA_W-1:0]      sum_in,
  input  logic                   cout_in,
  output logic                   res_valid,
  output logic [DATA_W:0]        res_data,
  input  logic                   res_ready,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [DROP_W-1:0]      drop_cnt
`ifdef RESULT_STATS_EN
  ,
  output logic [DROP_W-1:0]      carry_cnt,
  output logic [DATA_W-1:0]      max_sum
`endif
);

  localparam int unsigned ENTRY_W = DATA_W + 1;

  logic [LATENCY-1:0] tag_q;
  logic               cap;
  logic               pop;
  logic               push;
  logic               drop;
  logic [DROP_W-1:0]  drop_q;
  logic               fifo_full;
  logic               fifo_empty;

  // Tag delay line: stage 0 holds op_valid registered once.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q <= '0;
    end else begin
      tag_q[0] <= op_valid;
      for (int i = 1; i < LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  always_comb begin
    cap       = tag_q[LATENCY-1];
    res_valid = ~fifo_empty;
    pop       = res_valid & res_ready;
    push      = cap & (~fifo_full | pop);
    drop      = cap & fifo_full & ~pop;
    full      = fifo_full;
    empty     = fifo_empty;
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data ({cout_in, sum_in}),
    .rd_en   (pop),
    .rd_data (res_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= '0;
    end else if (drop && (drop_q != '1)) begin
      drop_q <= drop_q + DROP_W'(1);
    end
  end

  assign drop_cnt = drop_q;

`ifdef RESULT_STATS_EN
  logic [DROP_W-1:0] carry_q;
  logic [DATA_W-1:0] max_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q <= '0;
      max_q   <= '0;
    end else if (push) begin
      if (cout_in && (carry_q != '1)) carry_q <= carry_q + DROP_W'(1);
      if (sum_in > max_q) max_q <= sum_in;
    end
  end

  assign carry_cnt = carry_q;
  assign max_sum   = max_q;
`endif

endmodule

// File: tb/tb_adder_result_fifo.sv
module tb_adder_result_fifo;
  import adder_pipe_pkg::*;

  localparam int DW    = ADDER_W;
  localparam int LAT   = ADDER_LATENCY;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          op_valid;
  logic [DW-1:0] sum_in;
  logic          cout_in;
  logic          res_valid;
  logic [DW:0]   res_data;
  logic          res_ready;
  logic          full;
  logic          empty;
  logic [2:0]    count;
  logic [7:0]    drop_cnt;
`ifdef RESULT_STATS_EN
  logic [7:0]    carry_cnt;
  logic [DW-1:0] max_sum;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: a queue of buffered results plus counters, stepped once per clock.
  result_t       mq[$];
  logic          m_tag [LAT];
  int            m_drop  = 0;
  int            m_caps  = 0;
  int            m_carry = 0;
  int            m_max   = 0;

  adder_result_fifo dut (
    .clk       (clk),
    .rst       (rst),
    .op_valid  (op_valid),
    .sum_in    (sum_in),
    .cout_in   (cout_in),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_ready (res_ready),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .drop_cnt  (drop_cnt)
`ifdef RESULT_STATS_EN
    ,
    .carry_cnt (carry_cnt),
    .max_sum   (max_sum)
`endif
  );

  always #5 clk = ~clk;

  // Advance the model with the inputs currently applied, then let the DUT take the same edge.
  task automatic tick();
    logic cap;
    logic pop;
    cap = m_tag[LAT-1];
    pop = (mq.size() != 0) && res_ready;
    if (rst) begin
      mq.delete();
      m_drop  = 0;
      m_carry = 0;
      m_max   = 0;
      for (int i = 0; i < LAT; i++) m_tag[i] = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (cap) begin
        m_caps++;
        if (mq.size() < DEPTH) begin
          mq.push_back(pack_result(cout_in, sum_in));
          if (cout_in && m_carry < 255) m_carry++;
          if (int'(sum_in) > m_max) m_max = int'(sum_in);
        end else if (m_drop < 255) begin
          m_drop++;
        end
      end
      for (int i = LAT - 1; i > 0; i--) m_tag[i] = m_tag[i-1];
      m_tag[0] = op_valid;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got %b want 0", full); end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b want 0", res_valid); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (drop_cnt !== 8'd0) begin failures++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
    checks++; if (res_data !== 9'h000) begin failures++; $display("FAIL reset_data got %h want 000", res_data); end
  endtask

  task automatic test_latency();
    res_ready = 1'b0; op_valid = 1'b1; sum_in = 8'($urandom); cout_in = 1'b0;
    tick();
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL lat_early got %b want 0", res_valid); end
    op_valid = 1'b0; sum_in = 8'h5A; cout_in = 1'b1;
    tick();
    checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL lat_valid got %b want 1", res_valid); end
    checks++; if (res_data !== 9'h15A) begin failures++; $display("FAIL lat_data got %h want 15a", res_data); end
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL lat_count got %0d want 1", count); end
    for (int i = 0; i < 3; i++) begin
      sum_in = 8'($urandom); cout_in = 1'($urandom);
      tick();
      checks++; if (res_data !== 9'h15A || res_valid !== 1'b1) begin
        failures++; $display("FAIL lat_hold got %b/%h want 1/15a", res_valid, res_data); end
    end
`ifdef RESULT_STATS_EN
    checks++; if (carry_cnt !== 8'd1) begin failures++; $display("FAIL lat_carry got %0d want 1", carry_cnt); end
    checks++; if (max_sum !== 8'h5A) begin failures++; $display("FAIL lat_max got %h want 5a", max_sum); end
`endif
    res_ready = 1'b1;
    tick();
    checks++; if (empty !== 1'b1 || res_valid !== 1'b0) begin
      failures++; $display("FAIL lat_pop got empty=%b valid=%b want 1/0", empty, res_valid); end
    res_ready = 1'b0;
  endtask

  task automatic test_fill_overflow();
    res_ready = 1'b0; cout_in = 1'b0;
    for (int i = 0; i <= 6; i++) begin
      op_valid = (i < 6); sum_in = 8'(i);
      tick();
    end
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL fill_full got %b want 1", full); end
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL fill_count got %0d want 4", count); end
    checks++; if (drop_cnt !== 8'd2) begin failures++; $display("FAIL fill_drop got %0d want 2", drop_cnt); end
    res_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checks++; if (res_valid !== 1'b1 || res_data !== 9'(k)) begin
        failures++; $display("FAIL fill_order got %b/%h want 1/%h", res_valid, res_data, 9'(k)); end
      tick();
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL fill_drain got %b want 1", empty); end
    res_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    cout_in = 1'b0;
    for (int i = 0; i <= 5; i++) begin
      op_valid = (i < 5); sum_in = 8'(16 + i - 1); res_ready = (i == 5);
      tick();
    end
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL fullpop_count got %0d want 4", count); end
    checks++; if (drop_cnt !== 8'd2) begin failures++; $display("FAIL fullpop_drop got %0d want 2", drop_cnt); end
    checks++; if (res_data !== 9'h011) begin failures++; $display("FAIL fullpop_head got %h want 011", res_data); end
    res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (res_data !== 9'(17 + k)) begin
        failures++; $display("FAIL fullpop_order got %h want %h", res_data, 9'(17 + k)); end
      tick();
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL fullpop_drain got %b want 1", empty); end
    res_ready = 1'b0;
  endtask

  task automatic test_stream();
    int recv;
    int caps0;
    int drop0;
    recv = 0; caps0 = m_caps; drop0 = int'(drop_cnt);
    for (int i = 0; i < 100; i++) begin
      if (i < 80) begin
        op_valid = ($urandom_range(0, 3) != 0); res_ready = 1'($urandom);
      end else begin
        op_valid = 1'b0; res_ready = 1'b1;
      end
      sum_in = 8'($urandom); cout_in = 1'($urandom);
      checks++; if (res_valid !== (mq.size() != 0)) begin
        failures++; $display("FAIL stream_valid cyc %0d got %b want %b", i, res_valid, mq.size() != 0); end
      if (mq.size() != 0) begin
        checks++; if (res_data !== mq[0]) begin
          failures++; $display("FAIL stream_data cyc %0d got %h want %h", i, res_data, mq[0]); end
      end
      if (res_valid && res_ready) recv++;
      tick();
      checks++; if (int'(count) !== mq.size() || count > 3'd4) begin
        failures++; $display("FAIL stream_count cyc %0d got %0d want %0d", i, count, mq.size()); end
      checks++; if (int'(drop_cnt) !== m_drop) begin
        failures++; $display("FAIL stream_drop cyc %0d got %0d want %0d", i, drop_cnt, m_drop); end
    end
    checks++; if (m_caps - caps0 !== recv + int'(drop_cnt) - drop0 + int'(count)) begin
      failures++; $display("FAIL stream_conserve caps %0d got recv+drop+held %0d", m_caps - caps0,
                           recv + int'(drop_cnt) - drop0 + int'(count)); end
`ifdef RESULT_STATS_EN
    checks++; if (int'(carry_cnt) !== m_carry) begin
      failures++; $display("FAIL stream_carry got %0d want %0d", carry_cnt, m_carry); end
    checks++; if (int'(max_sum) !== m_max) begin
      failures++; $display("FAIL stream_max got %0d want %0d", max_sum, m_max); end
`endif
  endtask

  task automatic test_back_to_back();
    int drop0;
    drop0 = m_drop;
    res_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      op_valid = (i < 36); sum_in = 8'($urandom); cout_in = 1'($urandom);
      if (mq.size() != 0) begin
        checks++; if (res_data !== mq[0]) begin
          failures++; $display("FAIL b2b_data cyc %0d got %h want %h", i, res_data, mq[0]); end
      end
      tick();
      checks++; if (count > 3'd1 || int'(drop_cnt) !== drop0) begin
        failures++; $display("FAIL b2b_flow cyc %0d got count=%0d drop=%0d want <=1/%0d", i, count,
                             drop_cnt, drop0); end
    end
    res_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    res_ready = 1'b0; cout_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      op_valid = 1'b1; sum_in = 8'hF0 + 8'(i);
      tick();
    end
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL mid_precount got %0d want 3", count); end
    op_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (empty !== 1'b1 || count !== 3'd0) begin
      failures++; $display("FAIL mid_empty got empty=%b count=%0d want 1/0", empty, count); end
    checks++; if (drop_cnt !== 8'd0) begin failures++; $display("FAIL mid_drop got %0d want 0", drop_cnt); end
`ifdef RESULT_STATS_EN
    checks++; if (carry_cnt !== 8'd0 || max_sum !== 8'd0) begin
      failures++; $display("FAIL mid_stats got %0d/%0d want 0/0", carry_cnt, max_sum); end
`endif
    tick();
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL mid_inflight got %b want 0", res_valid); end
    op_valid = 1'b1;
    tick();
    op_valid = 1'b0; sum_in = 8'hC3; cout_in = 1'b0;
    tick();
    checks++; if (res_valid !== 1'b1 || res_data !== 9'h0C3) begin
      failures++; $display("FAIL mid_restart got %b/%h want 1/0c3", res_valid, res_data); end
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; sum_in = '0; cout_in = 1'b0; res_ready = 1'b0;
    for (int i = 0; i < LAT; i++) m_tag[i] = 1'b0;
    test_reset();
    test_latency();
    test_fill_overflow();
    test_full_pop();
    test_stream();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
